// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline: default widths, the x0 index
// and the layout of the ID/EX pipeline register.
package core_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CTRL_WIDTH = 16;

    localparam logic [DEF_ADDR_WIDTH-1:0] X0 = '0;

    typedef struct packed {
        logic                      valid;
        logic                      reg_wen;
        logic                      is_load;
        logic [DEF_ADDR_WIDTH-1:0] rd;
        logic [DEF_DATA_WIDTH-1:0] pc;
        logic [DEF_DATA_WIDTH-1:0] rs1_data;
        logic [DEF_DATA_WIDTH-1:0] rs2_data;
        logic [DEF_DATA_WIDTH-1:0] imm;
        logic [DEF_CTRL_WIDTH-1:0] ctrl;
    } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Resolves one source operand: x0, then the youngest matching producer
// (EX, MEM, WB), and finally the register-file read data.
module fwd_mux
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] sel,
    input  logic                  ex_hit_en,
    input  logic [ADDR_WIDTH-1:0] ex_rd,
    input  logic [DATA_WIDTH-1:0] ex_data,
    input  logic                  mem_wen,
    input  logic [ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  wb_wen,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic [DATA_WIDTH-1:0] data
);

    // WB bypass is needed because the register file only commits at the edge.
    always_comb begin
        data = rf_data;
        if (sel == X0)
            data = '0;
        else if (ex_hit_en && ex_rd == sel)
            data = ex_data;
        else if (mem_wen && mem_rd == sel)
            data = mem_data;
        else if (wb_wen && wb_rd == sel)
            data = wb_data;
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/operand-fetch stage: forwards operands, detects load-use hazards and
// holds the ID/EX pipeline register behind a valid/ready handshake.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CTRL_WIDTH = DEF_CTRL_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  ID_VALID,
    output logic                  ID_READY,
    input  logic [DATA_WIDTH-1:0] ID_PC,
    input  logic [ADDR_WIDTH-1:0] ID_RS1,
    input  logic [ADDR_WIDTH-1:0] ID_RS2,
    input  logic [ADDR_WIDTH-1:0] ID_RD,
    input  logic                  ID_RS1_USED,
    input  logic                  ID_RS2_USED,
    input  logic                  ID_REG_WEN,
    input  logic                  ID_IS_LOAD,
    input  logic [DATA_WIDTH-1:0] ID_IMM,
    input  logic [CTRL_WIDTH-1:0] ID_CTRL,
    output logic [ADDR_WIDTH-1:0] RS1_SEL,
    output logic [ADDR_WIDTH-1:0] RS2_SEL,
    input  logic [DATA_WIDTH-1:0] SRC1_DOUT,
    input  logic [DATA_WIDTH-1:0] SRC2_DOUT,
    input  logic [DATA_WIDTH-1:0] EX_ALU_RESULT,
    input  logic                  MEM_FWD_WEN,
    input  logic [ADDR_WIDTH-1:0] MEM_FWD_RD,
    input  logic [DATA_WIDTH-1:0] MEM_FWD_DATA,
    input  logic                  WB_WEN,
    input  logic [ADDR_WIDTH-1:0] WB_RD_SEL,
    input  logic [DATA_WIDTH-1:0] WB_DATA,
    input  logic                  FLUSH,
    output logic                  EX_VALID,
    input  logic                  EX_READY,
    output logic [DATA_WIDTH-1:0] EX_PC,
    output logic [DATA_WIDTH-1:0] EX_RS1_DATA,
    output logic [DATA_WIDTH-1:0] EX_RS2_DATA,
    output logic [DATA_WIDTH-1:0] EX_IMM,
    output logic [ADDR_WIDTH-1:0] EX_RD,
    output logic                  EX_REG_WEN,
    output logic                  EX_IS_LOAD,
    output logic [CTRL_WIDTH-1:0] EX_CTRL,
    output logic [31:0]           STALL_CNT
);

    id_ex_t                ex_q;
    logic [31:0]           stall_cnt;
    logic                  adv;
    logic                  hazard;
    logic                  ex_hit_en;
    logic [DATA_WIDTH-1:0] rs1_res;
    logic [DATA_WIDTH-1:0] rs2_res;

    assign adv = !ex_q.valid || EX_READY;

    // A load in EX has no data yet, so a dependent instruction must wait one cycle.
    assign hazard = ID_VALID && ex_q.valid && ex_q.is_load && ex_q.reg_wen &&
                    (ex_q.rd != X0) &&
                    ((ID_RS1_USED && ID_RS1 == ex_q.rd) ||
                     (ID_RS2_USED && ID_RS2 == ex_q.rd));

    assign ID_READY  = FLUSH || (adv && !hazard);
    assign ex_hit_en = ex_q.valid && ex_q.reg_wen && !ex_q.is_load;
    assign RS1_SEL   = ID_RS1;
    assign RS2_SEL   = ID_RS2;

    fwd_mux #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_fwd_rs1 (
        .sel(ID_RS1), .ex_hit_en(ex_hit_en), .ex_rd(ex_q.rd), .ex_data(EX_ALU_RESULT),
        .mem_wen(MEM_FWD_WEN), .mem_rd(MEM_FWD_RD), .mem_data(MEM_FWD_DATA),
        .wb_wen(WB_WEN), .wb_rd(WB_RD_SEL), .wb_data(WB_DATA),
        .rf_data(SRC1_DOUT), .data(rs1_res)
    );

    fwd_mux #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_fwd_rs2 (
        .sel(ID_RS2), .ex_hit_en(ex_hit_en), .ex_rd(ex_q.rd), .ex_data(EX_ALU_RESULT),
        .mem_wen(MEM_FWD_WEN), .mem_rd(MEM_FWD_RD), .mem_data(MEM_FWD_DATA),
        .wb_wen(WB_WEN), .wb_rd(WB_RD_SEL), .wb_data(WB_DATA),
        .rf_data(SRC2_DOUT), .data(rs2_res)
    );

    // Bubbles only kill the flags; payload fields keep their last value.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ex_q <= '0;
        end else if (FLUSH || (adv && (hazard || !ID_VALID))) begin
            ex_q.valid   <= 1'b0;
            ex_q.reg_wen <= 1'b0;
            ex_q.is_load <= 1'b0;
        end else if (adv) begin
            ex_q.valid    <= 1'b1;
            ex_q.reg_wen  <= ID_REG_WEN;
            ex_q.is_load  <= ID_IS_LOAD;
            ex_q.rd       <= ID_RD;
            ex_q.pc       <= ID_PC;
            ex_q.rs1_data <= rs1_res;
            ex_q.rs2_data <= rs2_res;
            ex_q.imm      <= ID_IMM;
            ex_q.ctrl     <= ID_CTRL;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            stall_cnt <= '0;
        else if (hazard && adv && !FLUSH && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign EX_VALID    = ex_q.valid;
    assign EX_REG_WEN  = ex_q.reg_wen;
    assign EX_IS_LOAD  = ex_q.is_load;
    assign EX_RD       = ex_q.rd;
    assign EX_PC       = ex_q.pc;
    assign EX_RS1_DATA = ex_q.rs1_data;
    assign EX_RS2_DATA = ex_q.rs2_data;
    assign EX_IMM      = ex_q.imm;
    assign EX_CTRL     = ex_q.ctrl;
    assign STALL_CNT   = stall_cnt;

endmodule
